// File: rtl/sim_time_pkg.sv
// Shared types and helpers for the simulation time base.
// Timestamps are 64-bit picosecond counts.
package sim_time_pkg;

   typedef logic [63:0] simtime_t;

   typedef enum logic {
      WT_IDLE = 1'b0,
      WT_BUSY = 1'b1
   } wait_state_e;

   localparam longint PS_PER_S = 64'sd1_000_000_000_000;

   // A zero frequency has no period, so it maps to 0 instead of dividing by zero.
   function automatic simtime_t freq2period(input longint freq_hz);
      if (freq_hz == 64'sd0) begin
         return '0;
      end
      return simtime_t'(PS_PER_S / freq_hz);
   endfunction

endpackage

// File: rtl/sim_time_waiter.sv
// One-shot relative-wait timer against the live timestamp.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   WT_IDLE | no wait pending; a start latches now + delta
//   WT_BUSY | waiting; leaves on the first edge where now >= deadline
import sim_time_pkg::*;

module sim_time_waiter (
   input  logic     i_clk,
   input  logic     i_rst_n,
   input  simtime_t i_now,
   input  logic     i_start,
   input  simtime_t i_delta,
   output logic     o_busy,
   output logic     o_done
);

   wait_state_e r_state;
   wait_state_e w_state_nxt;
   simtime_t    r_deadline;
   simtime_t    w_deadline_nxt;
   simtime_t    w_diff;
   logic        w_expired;
   logic        r_done;
   logic        w_done_nxt;

   // Sign of the wrapped difference keeps the compare valid across timestamp wrap.
   assign w_diff    = i_now - r_deadline;
   assign w_expired = ~w_diff[63];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= WT_IDLE;
         r_deadline <= '0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_deadline <= w_deadline_nxt;
         r_done     <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_deadline_nxt = r_deadline;
      w_done_nxt     = 1'b0;
      case (r_state)
         WT_IDLE: begin
            if (i_start) begin
               w_deadline_nxt = i_now + i_delta;
               w_state_nxt    = WT_BUSY;
            end
         end
         WT_BUSY: begin
            if (w_expired) begin
               w_state_nxt = WT_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = WT_IDLE;
      endcase
   end

   assign o_busy = (r_state == WT_BUSY);
   assign o_done = r_done;

endmodule

// File: rtl/sim_time.sv
// Free-running picosecond time base with snapshot capture and a relative-wait timer.
import sim_time_pkg::*;

module sim_time #(
   parameter longint unsigned CLK_PERIOD_PS = 64'd1000,
   parameter int              TIME_W        = 64
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   output logic [TIME_W-1:0] now_o,
   input  logic              snap_req_i,
   output logic [TIME_W-1:0] snap_o,
   input  logic              wait_start_i,
   input  logic [TIME_W-1:0] wait_ps_i,
   output logic              wait_busy_o,
   output logic              wait_done_o
);

   localparam logic [TIME_W-1:0] LP_STEP = TIME_W'(CLK_PERIOD_PS);

   logic [TIME_W-1:0] r_now;
   logic [TIME_W-1:0] r_snap;

   // Counter wraps silently modulo 2^TIME_W.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_now  <= '0;
         r_snap <= '0;
      end else begin
         r_now <= r_now + LP_STEP;
         if (snap_req_i) begin
            r_snap <= r_now;
         end
      end
   end

   sim_time_waiter u_waiter (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_now   (r_now),
      .i_start (wait_start_i),
      .i_delta (wait_ps_i),
      .o_busy  (wait_busy_o),
      .o_done  (wait_done_o)
   );

   assign now_o  = r_now;
   assign snap_o = r_snap;

endmodule

// File: tb/tb_sim_time.sv
// Directed bench for sim_time: counter, snapshot, waits, wrap and reset abort.
import sim_time_pkg::*;

module tb_sim_time;

   logic        clk_i;
   logic        rst_ni;
   logic [63:0] now_o;
   logic        snap_req_i;
   logic [63:0] snap_o;
   logic        wait_start_i;
   logic [63:0] wait_ps_i;
   logic        wait_busy_o;
   logic        wait_done_o;

   int n_chk = 0;
   int n_err = 0;

   localparam logic [63:0] NEAR_WRAP = 64'hFFFF_FFFF_FFFF_F830;
   localparam logic [63:0] WRAP_M1K  = 64'hFFFF_FFFF_FFFF_FC18;

   sim_time #(.CLK_PERIOD_PS(64'd1000), .TIME_W(64)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .now_o        (now_o),
      .snap_req_i   (snap_req_i),
      .snap_o       (snap_o),
      .wait_start_i (wait_start_i),
      .wait_ps_i    (wait_ps_i),
      .wait_busy_o  (wait_busy_o),
      .wait_done_o  (wait_done_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic chk_wait(input string tag, input logic busy_exp, input logic done_exp);
      chk({tag, "_busy"}, {63'd0, wait_busy_o}, {63'd0, busy_exp});
      chk({tag, "_done"}, {63'd0, wait_done_o}, {63'd0, done_exp});
   endtask

   initial begin
      rst_ni       = 1'b0;
      snap_req_i   = 1'b0;
      wait_start_i = 1'b0;
      wait_ps_i    = '0;
      #1;
      chk("rst_now", now_o, 64'd0);
      chk("rst_snap", snap_o, 64'd0);
      chk_wait("rst", 1'b0, 1'b0);

      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (5) tick();
      chk("now_5cyc", now_o, 64'd5000);
      chk("snap_5cyc", snap_o, 64'd0);
      chk_wait("idle_5cyc", 1'b0, 1'b0);

      // snapshot captured at now=7000
      tick();
      tick();
      chk("now_7000", now_o, 64'd7000);
      snap_req_i = 1'b1;
      tick();
      snap_req_i = 1'b0;
      chk("snap_cap", snap_o, 64'd7000);
      chk("now_8000", now_o, 64'd8000);
      tick();
      chk("snap_hold", snap_o, 64'd7000);
      chk("now_9000", now_o, 64'd9000);

      // wait 2500 from 10000: busy 3 cycles, done registered at now=13000
      tick();
      wait_start_i = 1'b1;
      wait_ps_i    = 64'd2500;
      tick();
      wait_start_i = 1'b0;
      chk_wait("w2500_c1", 1'b1, 1'b0);
      tick();
      chk_wait("w2500_c2", 1'b1, 1'b0);
      tick();
      chk_wait("w2500_c3", 1'b1, 1'b0);
      chk("w2500_now13k", now_o, 64'd13000);
      tick();
      chk_wait("w2500_exp", 1'b0, 1'b1);
      tick();
      chk_wait("w2500_after", 1'b0, 1'b0);

      // zero wait; start stays high while busy with a long delta that must be ignored
      wait_start_i = 1'b1;
      wait_ps_i    = 64'd0;
      tick();
      chk_wait("w0_c1", 1'b1, 1'b0);
      wait_ps_i = 64'd7777;
      tick();
      chk_wait("w0_exp", 1'b0, 1'b1);
      wait_start_i = 1'b0;
      tick();
      chk_wait("w0_after", 1'b0, 1'b0);
      chk("now_18000", now_o, 64'd18000);

      // preload near wrap; deadline 3000 lies past the wrap
      force dut.r_now = NEAR_WRAP;
      #1;
      release dut.r_now;
      chk("preload", now_o, NEAR_WRAP);
      wait_start_i = 1'b1;
      wait_ps_i    = 64'd5000;
      tick();
      wait_start_i = 1'b0;
      chk("wrap_m1k", now_o, WRAP_M1K);
      chk_wait("wrap_c1", 1'b1, 1'b0);
      tick();
      chk("wrap_zero", now_o, 64'd0);
      chk_wait("wrap_c2", 1'b1, 1'b0);
      tick();
      tick();
      tick();
      chk("wrap_now3000", now_o, 64'd3000);
      chk_wait("wrap_c5", 1'b1, 1'b0);
      tick();
      chk_wait("wrap_exp", 1'b0, 1'b1);

      // start on the done cycle is accepted back-to-back
      wait_start_i = 1'b1;
      wait_ps_i    = 64'd1000;
      tick();
      wait_start_i = 1'b0;
      chk_wait("b2b_c1", 1'b1, 1'b0);
      tick();
      chk_wait("b2b_exp", 1'b0, 1'b1);
      chk("b2b_now", now_o, 64'd6000);

      // reset mid-wait aborts with no done pulse
      wait_start_i = 1'b1;
      wait_ps_i    = 64'd100000;
      tick();
      wait_start_i = 1'b0;
      tick();
      chk_wait("abort_pre", 1'b1, 1'b0);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("abort_now", now_o, 64'd0);
      chk("abort_snap", snap_o, 64'd0);
      chk_wait("abort_rst", 1'b0, 1'b0);
      tick();
      chk_wait("abort_hold", 1'b0, 1'b0);
      rst_ni = 1'b1;
      tick();
      chk_wait("abort_rel1", 1'b0, 1'b0);
      tick();
      chk_wait("abort_rel2", 1'b0, 1'b0);
      chk("abort_now2k", now_o, 64'd2000);

      chk("freq2period_1m", freq2period(64'sd1_000_000), 64'd1_000_000);
      chk("freq2period_0", freq2period(64'sd0), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
